// File: rtl/fixed_point_div_seq.sv
// fixed_point_div_seq: sequential Q16.16 sign-magnitude divider (Newton-Raphson reciprocal, one shared multiplier); define FIXED_POINT_DIV_SEQ_EARLY_EXIT_EN to stop iterating once x settles
`timescale 1ns/1ps
module fixed_point_div_seq #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int ITERS = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] c,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam int M = N - 1;
    localparam logic [M-1:0] MAX = '1;
    localparam logic [M-1:0] TWO = M'(1) << (Q + 1);
`ifdef FIXED_POINT_DIV_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SEED, MUL_T, MUL_X, FINAL, DONE} state_t;

    state_t         state, state_n;
    logic [M-1:0]   ma, mb, x, e, x0, mul_a, mul_b, mul_r, e_n;
    logic [2*M-1:0] prod;
    logic [3:0]     cnt;
    logic           sign, sat, last;
    int             p, sh;

    // shared multiplier: operands picked by state, Q-aligned truncation, saturate on any high bit
    always_comb begin
        mul_a = (state == MUL_T) ? mb : (state == MUL_X) ? x : ma;
        mul_b = (state == MUL_X) ? e : x;
        prod  = ({{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b}) >> Q;
        sat   = |prod[2*M-1:M];
        mul_r = sat ? MAX : prod[M-1:0];
        e_n   = (mul_r >= TWO) ? '0 : TWO - mul_r;
    end

    // reciprocal seed from the leading one of |b| so that |b|*x0 lands in [0.5, 1)
    always_comb begin
        p = 0;
        for (int i = 0; i < M; i++) p = mb[i] ? i : p;
        sh = 2 * Q - p - 1;
        x0 = (sh > N - 2) ? MAX : M'(1) << sh;
    end

    assign last  = (cnt + 4'd1 == 4'(ITERS)) || (EARLY && mul_r == x);
    assign ready = (state == IDLE);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SEED : IDLE;
            SEED:    state_n = (mb == '0) ? DONE : MUL_T;
            MUL_T:   state_n = MUL_X;
            MUL_X:   state_n = last ? FINAL : MUL_T;
            FINAL:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: operand capture, iteration registers, and result/flags that change only with done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ma          <= '0;
            mb          <= '0;
            sign        <= 1'b0;
            x           <= '0;
            e           <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            c           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ma   <= a[M-1:0];
                    mb   <= b[M-1:0];
                    sign <= a[N-1] ^ b[N-1];
                end
                SEED: if (mb == '0) begin
                    c           <= {sign, MAX};
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                    done        <= 1'b1;
                end else begin
                    x   <= x0;
                    cnt <= '0;
                end
                MUL_T: e <= e_n;
                MUL_X: begin
                    x   <= mul_r;
                    cnt <= cnt + 4'd1;
                end
                FINAL: begin
                    c           <= {sign & (|mul_r), mul_r};
                    overflow    <= sat;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_div_seq.sv
// tb_fixed_point_div_seq: scoreboard bench for fixed_point_div_seq against an ideal-quotient model
`timescale 1ns/1ps
module tb_fixed_point_div_seq;
    localparam int ITERS = 5;
    localparam int LAT   = 2 * ITERS + 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          t0;
    } op_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] a = '0, b = '0, c;
    logic        ready, done, div_by_zero, overflow;
    int          cyc = 0, checks = 0, errors = 0, dones = 0;
    op_t         sb[$];
    logic [30:0] btab [7] = '{31'h10000, 31'h18000, 31'h20000, 31'h40000, 31'h28000, 31'h30000, 31'h08000};

    fixed_point_div_seq #(.N(32), .Q(16), .ITERS(ITERS)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .c(c), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // compare one completed operation against the ideal quotient of its sampled operands
    task automatic score(input op_t o);
        logic [30:0] ma = o.a[30:0];
        logic [30:0] mb = o.b[30:0];
        logic        s  = o.a[31] ^ o.b[31];
        int          lat = cyc - o.t0;
        longint      ideal, err;
        check("ready_in_done", ready, 0);
        if (mb == 0) begin
            check("lat_dbz", lat, 1);
            check("c_dbz", c, {s, 31'h7fffffff});
            check("dbz_flag", div_by_zero, 1);
            check("ovf_dbz", overflow, 0);
        end else begin
`ifdef FIXED_POINT_DIV_SEQ_EARLY_EXIT_EN
            check("lat_le", (lat <= LAT && lat >= 4) ? LAT : lat, LAT);
`else
            check("lat", lat, LAT);
`endif
            check("dbz_clear", div_by_zero, 0);
            ideal = (longint'(ma) << 16) / longint'(mb);
            if (ideal > 64'h7fffffff) begin
                check("c_sat", c, {s, 31'h7fffffff});
                check("ovf_flag", overflow, 1);
            end else begin
                check("ovf_clear", overflow, 0);
                if (ideal == 0) check("c_zero", c, 0);
                else begin
                    err = ideal - longint'(c[30:0]);
                    err = (err < 0) ? -err : err;
                    check("c_err_le4", (err <= 4) ? 0 : err, 0);
                    check("c_sign", c[31], s);
                end
            end
        end
    endtask

    // consumer side of the scoreboard
    always @(negedge clk) begin
        op_t o;
        if (!reset && done) begin
            dones++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                o = sb.pop_front();
                score(o);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", ready, 1);
        a = ai;
        b = bi;
        start = 1'b1;
        sb.push_back('{ai, bi, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check("ready_busy", ready, 0);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, d0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_c", c, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;

        run_op(32'h00010000, 32'h00040000);
        run_op(32'h80030000, 32'h00018000);
        run_op(32'h00000000, 32'h80018000);
        run_op(32'h00050000, 32'h80000000);
        run_op(32'h00050000, 32'h00000000);
        run_op(32'h00020000, 32'h00010000);
        run_op(32'h40000000, 32'h00000100);
        run_op(32'h00010000, 32'h00010000);
        run_op(32'h00008000, 32'h00008000);

        // start held high with operands changing every cycle
        @(negedge clk);
        d0 = dones;
        acc = 0;
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = {1'($urandom), 31'($urandom_range(32'h20000, 32'h1000))};
            b = {1'($urandom), btab[$urandom_range(6, 0)]};
            if (ready) begin
                sb.push_back('{a, b, cyc + 1});
                acc++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        check("stream_dones", dones - d0, acc);

        // reset in the middle of an operation
        @(negedge clk);
        d0 = dones;
        a = 32'h00010000;
        b = 32'h00040000;
        start = 1'b1;
        sb.push_back('{a, b, cyc + 1});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_c", c, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", dones - d0, 0);
        check("idle_after_reset", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
